// File: rtl/key_press_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_press_conditioner_pkg
// Purpose  : Shared channel-state encodings and key index constants.
// Revision : 1.0
// ============================================================================
package key_press_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HELD = 2'd2,
        ST_REL  = 2'd3
    } chan_state_t;

    localparam int KEY_HIT   = 0;
    localparam int KEY_STAND = 1;
    localparam int KEY_DEAL  = 2;

endpackage : key_press_conditioner_pkg
`default_nettype wire

// File: rtl/key_press_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : key_press_conditioner_if
// Purpose  : Raw key pins in, conditioned press pulses and levels out.
// Revision : 1.0
// ============================================================================
interface key_press_conditioner_if #(
    parameter int NUM_KEYS = 3
);
    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] press_pulse;
    logic [NUM_KEYS-1:0] key_level;
    logic                any_press;

    modport master (
        output key_n,
        input  press_pulse,
        input  key_level,
        input  any_press
    );

    modport slave (
        input  key_n,
        output press_pulse,
        output key_level,
        output any_press
    );
endinterface : key_press_conditioner_if
`default_nettype wire

// File: rtl/key_press_conditioner_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_press_conditioner_debounce
// Purpose  : One key channel: 2-flop sync, stability counter and press FSM.
// Revision : 1.0
// ============================================================================
module key_press_conditioner_debounce
    import key_press_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic key_n,
    output logic      req,
    output logic      level_nxt
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_q1;
    logic             ks;
    chan_state_t      state_q;
    chan_state_t      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pressed;

    // Sync flops reset to the released level so a key held through reset is seen as a new press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b1;
            ks      <= 1'b1;
        end else begin
            sync_q1 <= key_n;
            ks      <= sync_q1;
        end
    end

    assign pressed = ~ks;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pressed) begin
                    state_d = ST_ARM;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_ARM: begin
                if (!pressed) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    req     = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!pressed) begin
                    state_d = ST_REL;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_REL: begin
                if (pressed) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Level follows the next state so the registered level rises with the pulse
    assign level_nxt = (state_d == ST_HELD) || (state_d == ST_REL);

endmodule : key_press_conditioner_debounce
`default_nettype wire

// File: rtl/key_press_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : key_press_conditioner
// Purpose  : Debounced key channels with highest-index press arbitration.
// Revision : 1.0
// ============================================================================
module key_press_conditioner #(
    parameter int NUM_KEYS        = 3,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    key_press_conditioner_if.slave kif
);
    logic [NUM_KEYS-1:0] req;
    logic [NUM_KEYS-1:0] level_nxt;
    logic [NUM_KEYS-1:0] grant;
    logic [NUM_KEYS-1:0] press_pulse_q;
    logic [NUM_KEYS-1:0] key_level_q;
    logic                any_press_q;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        key_press_conditioner_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .key_n     (kif.key_n[i]),
            .req       (req[i]),
            .level_nxt (level_nxt[i])
        );
    end

    // Highest requesting index wins; lower simultaneous requests are dropped
    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_pulse_q <= '0;
            key_level_q   <= '0;
            any_press_q   <= 1'b0;
        end else begin
            press_pulse_q <= grant;
            key_level_q   <= level_nxt;
            any_press_q   <= |grant;
        end
    end

    assign kif.press_pulse = press_pulse_q;
    assign kif.key_level   = key_level_q;
    assign kif.any_press   = any_press_q;

endmodule : key_press_conditioner
`default_nettype wire
